// File: rtl/c1_bus_master_if.sv
// Request/response handshake between a CPU-side client and c1_bus_master.
// The client uses the master modport; the bus engine uses the slave modport.
interface c1_bus_master_if #(
    parameter int CMD_W  = 3,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [CMD_W-1:0]  req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic              busy;

    modport master (
        output req_valid, req_cmd, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
    );
endinterface

// File: rtl/c1_bus_master.sv
// CPU-side master for the shared tri-state C1/A1/D1 cache bus.
// Serialises one command, releases the bus, then waits for C1_RESPONSE.
module c1_bus_master #(
    parameter int TAG_SET_SIZE   = 15,
    parameter int OFFSET_SIZE    = 4,
    parameter int DATA1_BUS_SIZE = 16,
    parameter int CTR1_BUS_SIZE  = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RESET,
    c1_bus_master_if.slave            host,
    inout  wire [CTR1_BUS_SIZE-1:0]   C1_WIRE,
    inout  wire [TAG_SET_SIZE-1:0]    A1_WIRE,
    inout  wire [DATA1_BUS_SIZE-1:0]  D1_WIRE
);
    localparam int ADDR_W = TAG_SET_SIZE + OFFSET_SIZE;
    localparam int DW     = DATA1_BUS_SIZE;
    localparam int DW2    = 2 * DATA1_BUS_SIZE;

    localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP      = CTR1_BUS_SIZE'(0);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8    = CTR1_BUS_SIZE'(1);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16   = CTR1_BUS_SIZE'(2);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32   = CTR1_BUS_SIZE'(3);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8   = CTR1_BUS_SIZE'(5);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16  = CTR1_BUS_SIZE'(6);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32  = CTR1_BUS_SIZE'(7);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE = CTR1_BUS_SIZE'(7);

    // A zero limit disables the timeout; the counter then just saturates.
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT =
        TMO_EN ? CNT_W'(TIMEOUT_CYCLES) : {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_AHI,
        S_ALO,
        S_WHI,
        S_WAIT,
        S_RHI,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CTR1_BUS_SIZE-1:0] cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW2-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW2-1:0]    rdata_q, rdata_d;
    logic              tmo_q, tmo_d;

    logic              c1_oe, a1_oe, d1_oe;
    logic [TAG_SET_SIZE-1:0] a1_out;
    logic [DW-1:0]     d1_out;
    logic              is_write;

    assign is_write = (cmd_q == C1_WRITE8) || (cmd_q == C1_WRITE16) ||
                      (cmd_q == C1_WRITE32);

    // State and transaction registers; reset releases the bus at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    // Bus drivers depend only on registered state, never on the bus itself.
    always_comb begin
        c1_oe  = 1'b0;
        a1_oe  = 1'b0;
        d1_oe  = 1'b0;
        a1_out = '0;
        d1_out = '0;
        unique case (state_q)
            S_AHI: begin
                c1_oe  = 1'b1;
                a1_oe  = 1'b1;
                a1_out = addr_q[ADDR_W-1:OFFSET_SIZE];
            end
            S_ALO: begin
                c1_oe  = 1'b1;
                a1_oe  = 1'b1;
                a1_out = TAG_SET_SIZE'(addr_q[OFFSET_SIZE-1:0]);
                d1_oe  = is_write;
                if (cmd_q == C1_WRITE8)
                    d1_out = {{(DW-8){1'b0}}, wdata_q[7:0]};
                else
                    d1_out = wdata_q[DW-1:0];
            end
            S_WHI: begin
                c1_oe  = 1'b1;
                d1_oe  = 1'b1;
                d1_out = wdata_q[DW2-1:DW];
            end
            default: begin
            end
        endcase
    end

    assign C1_WIRE = c1_oe ? cmd_q  : {CTR1_BUS_SIZE{1'bz}};
    assign A1_WIRE = a1_oe ? a1_out : {TAG_SET_SIZE{1'bz}};
    assign D1_WIRE = d1_oe ? d1_out : {DW{1'bz}};

    // Next-state: accept, address beats, write beat, wait, read beat, done.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (host.req_valid) begin
                    cmd_d   = host.req_cmd;
                    addr_d  = host.req_addr;
                    wdata_d = host.req_wdata;
                    if (host.req_cmd != C1_NOP)
                        state_d = S_AHI;
                end
            end
            S_AHI: begin
                state_d = S_ALO;
            end
            S_ALO: begin
                cnt_d   = '0;
                state_d = (cmd_q == C1_WRITE32) ? S_WHI : S_WAIT;
            end
            S_WHI: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (C1_WIRE == C1_RESPONSE) begin
                    tmo_d   = 1'b0;
                    state_d = S_DONE;
                    case (cmd_q)
                        C1_READ8:  rdata_d = DW2'(D1_WIRE[7:0]);
                        C1_READ16: rdata_d = DW2'(D1_WIRE);
                        C1_READ32: begin
                            rdata_d = DW2'(D1_WIRE);
                            state_d = S_RHI;
                        end
                        default:   rdata_d = '0;
                    endcase
                end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RHI: begin
                rdata_d = {D1_WIRE, rdata_q[DW-1:0]};
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign host.req_ready   = (state_q == S_IDLE);
    assign host.busy        = (state_q != S_IDLE);
    assign host.rsp_valid   = (state_q == S_DONE);
    assign host.rsp_timeout = (state_q == S_DONE) && tmo_q;
    assign host.rsp_rdata   = rdata_q;
endmodule

// File: tb/tb_c1_bus_master.sv
// Self-checking bench for c1_bus_master with a behavioural cache model.
// Released buses are detected by overdriving them with probe values.
module tb_c1_bus_master;
    localparam int TS  = 15;
    localparam int OS  = 4;
    localparam int DW  = 16;
    localparam int CW  = 3;
    localparam int TMO = 4;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] R8    = 3'd1;
    localparam logic [2:0] R16   = 3'd2;
    localparam logic [2:0] R32   = 3'd3;
    localparam logic [2:0] INV   = 3'd4;
    localparam logic [2:0] W8    = 3'd5;
    localparam logic [2:0] W16   = 3'd6;
    localparam logic [2:0] W32   = 3'd7;
    localparam logic [2:0] RESP  = 3'd7;

    typedef struct {
        bit          c_drv;
        logic [2:0]  c;
        bit          a_drv;
        logic [14:0] a;
        bit          d_drv;
        logic [15:0] d;
    } phase_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    c1_bus_master_if #(.CMD_W(CW), .ADDR_W(TS + OS), .DATA_W(2 * DW)) host ();

    wire [CW-1:0] C1_WIRE;
    wire [TS-1:0] A1_WIRE;
    wire [DW-1:0] D1_WIRE;

    logic          c1_en, a1_en, d1_en;
    logic [CW-1:0] c1_tb;
    logic [TS-1:0] a1_tb;
    logic [DW-1:0] d1_tb;

    assign C1_WIRE = c1_en ? c1_tb : 'z;
    assign A1_WIRE = a1_en ? a1_tb : 'z;
    assign D1_WIRE = d1_en ? d1_tb : 'z;

    c1_bus_master #(
        .TAG_SET_SIZE  (TS),
        .OFFSET_SIZE   (OS),
        .DATA1_BUS_SIZE(DW),
        .CTR1_BUS_SIZE (CW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .host   (host),
        .C1_WIRE(C1_WIRE),
        .A1_WIRE(A1_WIRE),
        .D1_WIRE(D1_WIRE)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd = 32'h0;

    // Expected response data straight from the command semantics.
    function automatic logic [31:0] model_rdata(input logic [2:0] cmd,
        input logic [15:0] lo, input logic [15:0] hi, input bit tmo);
        if (tmo) return 32'h0;
        case (cmd)
            R8:      return {24'h0, lo[7:0]};
            R16:     return {16'h0, lo};
            R32:     return {hi, lo};
            default: return 32'h0;
        endcase
    endfunction

    task automatic release_bus();
        c1_en = 1'b0;
        a1_en = 1'b0;
        d1_en = 1'b0;
    endtask

    task automatic drive_probes(input bit c, input bit a, input bit d);
        c1_en = c;
        a1_en = a;
        d1_en = d;
        c1_tb = 3'($urandom_range(0, 6));
        a1_tb = 15'($urandom);
        d1_tb = 16'($urandom);
    endtask

    // One complete transaction; cache answers in WAIT cycle 'delay' (<0: never).
    task automatic do_txn(input string nm, input logic [2:0] cmd,
        input logic [18:0] addr, input logic [31:0] wdata, input int delay,
        input logic [15:0] lo, input logic [15:0] hi);
        phase_t ph[$];
        phase_t p;
        bit tmo;
        bit wr;
        bit seen;
        int exp_cyc;
        logic [31:0] exp_rd;
        logic [15:0] d_lo;
        wr = (cmd == W8) || (cmd == W16) || (cmd == W32);
        tmo = (delay < 0) || (delay >= TMO);
        exp_cyc = tmo ? TMO : delay + ((cmd == R32) ? 2 : 1);
        exp_rd = model_rdata(cmd, lo, hi, tmo);
        d_lo = (cmd == W8) ? {8'h0, wdata[7:0]} : wdata[15:0];
        p = '{1'b1, cmd, 1'b1, addr[18:4], 1'b0, 16'h0};
        ph.push_back(p);
        p = '{1'b1, cmd, 1'b1, {11'h0, addr[3:0]}, wr, d_lo};
        ph.push_back(p);
        if (cmd == W32) begin
            p = '{1'b1, cmd, 1'b0, 15'h0, 1'b1, wdata[31:16]};
            ph.push_back(p);
        end

        release_bus();
        host.req_valid = 1'b1;
        host.req_cmd   = cmd;
        host.req_addr  = addr;
        host.req_wdata = wdata;
        #1;
        checks++;
        if (host.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: got %b want 1", nm, host.req_ready);
        end
        @(negedge CLK);
        host.req_valid = 1'b0;
        host.req_wdata = $urandom;
        host.req_addr  = 19'($urandom);

        foreach (ph[i]) begin
            drive_probes(!ph[i].c_drv, !ph[i].a_drv, !ph[i].d_drv);
            #1;
            checks++;
            if (C1_WIRE !== (ph[i].c_drv ? ph[i].c : c1_tb)) begin
                errors++;
                $display("FAIL %s C1 beat%0d: got %h want %h", nm, i,
                         C1_WIRE, ph[i].c_drv ? ph[i].c : c1_tb);
            end
            checks++;
            if (A1_WIRE !== (ph[i].a_drv ? ph[i].a : a1_tb)) begin
                errors++;
                $display("FAIL %s A1 beat%0d: got %h want %h", nm, i,
                         A1_WIRE, ph[i].a_drv ? ph[i].a : a1_tb);
            end
            checks++;
            if (D1_WIRE !== (ph[i].d_drv ? ph[i].d : d1_tb)) begin
                errors++;
                $display("FAIL %s D1 beat%0d: got %h want %h", nm, i,
                         D1_WIRE, ph[i].d_drv ? ph[i].d : d1_tb);
            end
            @(negedge CLK);
        end

        seen = 1'b0;
        for (int cyc = 0; cyc <= TMO + 4 && !seen; cyc++) begin
            drive_probes(1'b1, 1'b1, 1'b1);
            if (!tmo && cyc == delay) begin
                c1_tb = RESP;
                d1_tb = lo;
            end else if (!tmo && cmd == R32 && cyc == delay + 1) begin
                d1_tb = hi;
            end
            #1;
            checks++;
            if (C1_WIRE !== c1_tb || A1_WIRE !== a1_tb || D1_WIRE !== d1_tb) begin
                errors++;
                $display("FAIL %s bus not released cyc%0d: got %h/%h/%h want %h/%h/%h",
                         nm, cyc, C1_WIRE, A1_WIRE, D1_WIRE, c1_tb, a1_tb, d1_tb);
            end
            if (host.rsp_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (cyc != exp_cyc) begin
                    errors++;
                    $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_cyc);
                end
                checks++;
                if (host.rsp_timeout !== tmo) begin
                    errors++;
                    $display("FAIL %s rsp_timeout: got %b want %b", nm,
                             host.rsp_timeout, tmo);
                end
                checks++;
                if (host.rsp_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL %s rsp_rdata: got %h want %h", nm,
                             host.rsp_rdata, exp_rd);
                end
                checks++;
                if (host.busy !== 1'b1 || host.req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done flags: got busy=%b ready=%b want 1 0", nm,
                             host.busy, host.req_ready);
                end
            end else begin
                @(negedge CLK);
            end
        end

        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s rsp_valid: got none want pulse", nm);
        end else begin
            @(negedge CLK);
            #1;
            checks++;
            if (host.rsp_valid !== 1'b0 || host.busy !== 1'b0 ||
                host.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s after done: got v=%b busy=%b ready=%b want 0 0 1",
                         nm, host.rsp_valid, host.busy, host.req_ready);
            end
            checks++;
            if (host.rsp_rdata !== exp_rd) begin
                errors++;
                $display("FAIL %s rdata hold: got %h want %h", nm,
                         host.rsp_rdata, exp_rd);
            end
        end
        last_rd = exp_rd;
        release_bus();
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        host.req_valid = 1'b0;
        host.req_cmd   = C_NOP;
        host.req_addr  = '0;
        host.req_wdata = '0;
        release_bus();
        repeat (2) @(negedge CLK);
        drive_probes(1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (host.rsp_valid !== 1'b0 || host.rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset rsp: got v=%b t=%b want 0 0",
                     host.rsp_valid, host.rsp_timeout);
        end
        checks++;
        if (host.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset rdata: got %h want 0", host.rsp_rdata);
        end
        checks++;
        if (host.busy !== 1'b0 || host.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset flags: got busy=%b ready=%b want 0 1",
                     host.busy, host.req_ready);
        end
        checks++;
        if (C1_WIRE !== c1_tb || A1_WIRE !== a1_tb || D1_WIRE !== d1_tb) begin
            errors++;
            $display("FAIL reset bus: got %h/%h/%h want %h/%h/%h", C1_WIRE,
                     A1_WIRE, D1_WIRE, c1_tb, a1_tb, d1_tb);
        end
        RESET = 1'b1;
        release_bus();
        last_rd = 32'h0;
    endtask

    task automatic test_invalidate();
        do_txn("invalidate", INV, {15'd1, 4'd2}, 32'h0, 1, 16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_write32();
        do_txn("write32", W32, 19'h2A5A3, 32'hDEADBEEF, 0, 16'h5555, 16'h0);
    endtask

    task automatic test_read32();
        do_txn("read32", R32, 19'h12345, 32'h0, 2, 16'h1234, 16'h5678);
    endtask

    task automatic test_read8();
        do_txn("read8", R8, 19'h00F0F, 32'h0, 0, 16'hABCD, 16'h0);
    endtask

    task automatic test_nop();
        @(negedge CLK);
        #1;
        host.req_valid = 1'b1;
        host.req_cmd   = C_NOP;
        host.req_addr  = 19'($urandom);
        @(negedge CLK);
        #1;
        host.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_probes(1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (host.busy !== 1'b0 || host.rsp_valid !== 1'b0 ||
                host.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL nop flags: got busy=%b v=%b ready=%b want 0 0 1",
                         host.busy, host.rsp_valid, host.req_ready);
            end
            checks++;
            if (C1_WIRE !== c1_tb || A1_WIRE !== a1_tb || D1_WIRE !== d1_tb) begin
                errors++;
                $display("FAIL nop bus: got %h/%h/%h want %h/%h/%h", C1_WIRE,
                         A1_WIRE, D1_WIRE, c1_tb, a1_tb, d1_tb);
            end
            checks++;
            if (host.rsp_rdata !== last_rd) begin
                errors++;
                $display("FAIL nop rdata hold: got %h want %h",
                         host.rsp_rdata, last_rd);
            end
            @(negedge CLK);
        end
        #1;
        release_bus();
    endtask

    task automatic test_timeout();
        do_txn("timeout", R16, 19'h7FFFF, 32'h0, -1, 16'h0, 16'h0);
    endtask

    task automatic test_resp_at_limit();
        do_txn("at_limit", R16, 19'h0ABCD, 32'h0, TMO - 1, 16'hC0DE, 16'h0);
    endtask

    task automatic test_reset_mid();
        host.req_valid = 1'b1;
        host.req_cmd   = W16;
        host.req_addr  = 19'h15555;
        host.req_wdata = 32'h0000F00D;
        @(negedge CLK);
        host.req_valid = 1'b0;
        @(negedge CLK);
        drive_probes(1'b1, 1'b1, 1'b1);
        RESET = 1'b0;
        #1;
        checks++;
        if (C1_WIRE !== c1_tb || A1_WIRE !== a1_tb || D1_WIRE !== d1_tb) begin
            errors++;
            $display("FAIL reset_mid bus: got %h/%h/%h want %h/%h/%h", C1_WIRE,
                     A1_WIRE, D1_WIRE, c1_tb, a1_tb, d1_tb);
        end
        checks++;
        if (host.busy !== 1'b0 || host.req_ready !== 1'b1 ||
            host.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid flags: got busy=%b ready=%b v=%b want 0 1 0",
                     host.busy, host.req_ready, host.rsp_valid);
        end
        checks++;
        if (host.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid rdata: got %h want 0", host.rsp_rdata);
        end
        last_rd = 32'h0;
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        release_bus();
        do_txn("after_reset", R16, 19'h3C3C3, 32'h0, 1, 16'h9A9A, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [2:0] cmds [7];
        cmds = '{R8, R16, R32, INV, W8, W16, W32};
        for (int i = 0; i < 24; i++) begin
            do_txn($sformatf("rand%0d", i), cmds[$urandom_range(0, 6)],
                   19'($urandom), $urandom, int'($urandom_range(0, 5)) - 1,
                   16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_invalidate();
        test_write32();
        test_read32();
        test_read8();
        test_nop();
        test_timeout();
        test_resp_at_limit();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
